// File: rtl/mrd_rdx2345_pkg.sv
// Shared definitions for the radix-2/3/4/5 read sequencer.
// Holds the FSM state encoding, the legal radix range and the bank-index width.
package mrd_rdx2345_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int unsigned FSM_W     = 2;
  localparam int unsigned BANK_W    = 3;
  localparam int unsigned RADIX_MIN = 2;
  localparam int unsigned RADIX_MAX = 5;

  // True when the requested radix can be sequenced.
  function automatic logic radix_legal(input logic [2:0] radix);
    return (radix >= 3'(RADIX_MIN)) && (radix <= 3'(RADIX_MAX));
  endfunction

endpackage

// File: rtl/mrd_rdx2345_if.sv
// Sample stream from the read sequencer to the twiddle stage.
// Every field is aligned with the returned read data it accompanies.
interface mrd_rdx2345_if #(
  parameter int DW = 18,
  parameter int AW = 8
);
  import mrd_rdx2345_pkg::*;

  logic [FSM_W-1:0]  fsm;
  logic              valid;
  logic [DW-1:0]     d_real;
  logic [DW-1:0]     d_imag;
  logic [BANK_W-1:0] bank_index;
  logic [AW-1:0]     bank_addr;
  logic [1:0]        tw_ROM_sel;
  logic [AW-1:0]     tw_ROM_addr_step;
  logic [2:0]        tw_ROM_exp_ceil;
  logic [BANK_W-1:0] tw_ROM_exp_time;

  modport master (
    output fsm, valid, d_real, d_imag, bank_index, bank_addr,
           tw_ROM_sel, tw_ROM_addr_step, tw_ROM_exp_ceil, tw_ROM_exp_time
  );

  modport slave (
    input  fsm, valid, d_real, d_imag, bank_index, bank_addr,
           tw_ROM_sel, tw_ROM_addr_step, tw_ROM_exp_ceil, tw_ROM_exp_time
  );

endinterface

// File: rtl/mrd_dly_line.sv
// Fixed-depth register delay line with asynchronous active-high clear.
// Used to align read sideband with the bank memory's read latency.
module mrd_dly_line #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage [DEPTH];

  // Shift register; every stage clears on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/mrd_rdx2345_rdseq.sv
// Radix-2/3/4/5 stage read sequencer.
// Walks bank k (inner, 0..radix-1) and address g (outer, 0..ngrp-1), issuing
// one bank read per unstalled cycle, and forwards returned data to the twiddle
// stage together with sideband delayed by RD_LAT cycles.
// Optional build macro MRD_RDSEQ_PERF_EN adds a 16-bit saturating stall counter
// output perf_cnt (stall cycles seen in ISSUE, cleared at each accepted start).
module mrd_rdx2345_rdseq
  import mrd_rdx2345_pkg::*;
#(
  parameter int DW     = 18,
  parameter int AW     = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        cfg_radix,
  input  logic [AW-1:0]     cfg_ngrp,
  input  logic [1:0]        cfg_tw_sel,
  input  logic [AW-1:0]     cfg_tw_step,
  input  logic [2:0]        cfg_exp_ceil,
  input  logic              stall,
  output logic              mem_rd_en,
  output logic [BANK_W-1:0] mem_rd_bank,
  output logic [AW-1:0]     mem_rd_addr,
  input  logic [DW-1:0]     mem_rdata_real,
  input  logic [DW-1:0]     mem_rdata_imag,
  mrd_rdx2345_if.master     to_twdl,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
`ifdef MRD_RDSEQ_PERF_EN
  ,
  output logic [15:0]       perf_cnt
`endif
);

  localparam int unsigned SB_W = FSM_W + 1 + BANK_W + AW + 2 + AW + 3;

  state_t            state;
  logic [BANK_W-1:0] k;
  logic [AW-1:0]     g;
  logic [1:0]        drain_cnt;
  logic [2:0]        radix_q;
  logic [AW-1:0]     ngrp_q;
  logic [1:0]        tw_sel_q;
  logic [AW-1:0]     tw_step_q;
  logic [2:0]        exp_ceil_q;
  logic              issue;
  logic              accept;

  logic [SB_W-1:0]   sb_in;
  logic [SB_W-1:0]   sb_out;
  logic [FSM_W-1:0]  sb_fsm;
  logic              sb_valid;
  logic [BANK_W-1:0] sb_bank;
  logic [AW-1:0]     sb_addr;
  logic [1:0]        sb_sel;
  logic [AW-1:0]     sb_step;
  logic [2:0]        sb_ceil;

  // Stall gates the read strobe in the same cycle so no read is lost or doubled.
  assign issue       = (state == ST_ISSUE) && !stall;
  assign accept      = (state == ST_IDLE) && start && radix_legal(cfg_radix) && (cfg_ngrp != '0);
  assign mem_rd_en   = issue;
  assign mem_rd_bank = issue ? k : '0;
  assign mem_rd_addr = issue ? g : '0;
  assign busy        = (state != ST_IDLE);

  // Sequencer FSM: config latch, bank/address walk, drain and completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      k          <= '0;
      g          <= '0;
      drain_cnt  <= '0;
      radix_q    <= '0;
      ngrp_q     <= '0;
      tw_sel_q   <= '0;
      tw_step_q  <= '0;
      exp_ceil_q <= '0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (!radix_legal(cfg_radix)) begin
              cfg_err <= 1'b1;
              done    <= 1'b1;
            end else if (cfg_ngrp == '0) begin
              done <= 1'b1;
            end else begin
              radix_q    <= cfg_radix;
              ngrp_q     <= cfg_ngrp;
              tw_sel_q   <= cfg_tw_sel;
              tw_step_q  <= cfg_tw_step;
              exp_ceil_q <= cfg_exp_ceil;
              cfg_err    <= 1'b0;
              k          <= '0;
              g          <= '0;
              state      <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (!stall) begin
            if (k == radix_q - 3'd1) begin
              k <= '0;
              if (g == ngrp_q - AW'(1)) begin
                g         <= '0;
                drain_cnt <= '0;
                state     <= ST_DRAIN;
              end else begin
                g <= g + AW'(1);
              end
            end else begin
              k <= k + 3'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == 2'(RD_LAT - 1)) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MRD_RDSEQ_PERF_EN
  // Saturating count of stalled ISSUE cycles for the current stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cnt <= '0;
    end else if (accept) begin
      perf_cnt <= '0;
    end else if ((state == ST_ISSUE) && stall && (perf_cnt != 16'hFFFF)) begin
      perf_cnt <= perf_cnt + 16'd1;
    end
  end
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

  // Bank and address are taken from the gated read port, so idle slots carry zeros.
  assign sb_in = {state, issue, mem_rd_bank, mem_rd_addr, tw_sel_q, tw_step_q, exp_ceil_q};

  mrd_dly_line #(
    .W     (SB_W),
    .DEPTH (RD_LAT)
  ) u_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (sb_in),
    .dout (sb_out)
  );

  assign {sb_fsm, sb_valid, sb_bank, sb_addr, sb_sel, sb_step, sb_ceil} = sb_out;

  // Read data arrives exactly with the delayed valid, so it passes straight through.
  assign to_twdl.fsm              = sb_fsm;
  assign to_twdl.valid            = sb_valid;
  assign to_twdl.d_real           = sb_valid ? mem_rdata_real : '0;
  assign to_twdl.d_imag           = sb_valid ? mem_rdata_imag : '0;
  assign to_twdl.bank_index       = sb_bank;
  assign to_twdl.bank_addr        = sb_addr;
  assign to_twdl.tw_ROM_sel       = sb_sel;
  assign to_twdl.tw_ROM_addr_step = sb_step;
  assign to_twdl.tw_ROM_exp_ceil  = sb_ceil;
  assign to_twdl.tw_ROM_exp_time  = sb_bank;

endmodule

// File: tb/tb_mrd_rdx2345_rdseq.sv
// Self-checking bench for mrd_rdx2345_rdseq with a latency-accurate bank memory model.
module tb_mrd_rdx2345_rdseq;
  import mrd_rdx2345_pkg::*;

  localparam int DW     = 18;
  localparam int AW     = 8;
  localparam int RD_LAT = 2;

  typedef struct packed {
    logic [2:0]    bank;
    logic [AW-1:0] addr;
  } rd_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    cfg_radix = '0;
  logic [AW-1:0] cfg_ngrp = '0;
  logic [1:0]    cfg_tw_sel = '0;
  logic [AW-1:0] cfg_tw_step = '0;
  logic [2:0]    cfg_exp_ceil = '0;
  logic          stall = 1'b0;
  logic          mem_rd_en;
  logic [2:0]    mem_rd_bank;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rdata_real;
  logic [DW-1:0] mem_rdata_imag;
  logic          busy;
  logic          done;
  logic          cfg_err;
`ifdef MRD_RDSEQ_PERF_EN
  logic [15:0]   perf_cnt;
`endif

  int checks = 0;
  int failures = 0;

  rd_t rd_q[$];
  rd_t out_q[$];
  logic [1:0]    exp_sel;
  logic [AW-1:0] exp_step;
  logic [2:0]    exp_ceil;

  mrd_rdx2345_if #(.DW(DW), .AW(AW)) twdl_if ();

  mrd_rdx2345_rdseq #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cfg_radix      (cfg_radix),
    .cfg_ngrp       (cfg_ngrp),
    .cfg_tw_sel     (cfg_tw_sel),
    .cfg_tw_step    (cfg_tw_step),
    .cfg_exp_ceil   (cfg_exp_ceil),
    .stall          (stall),
    .mem_rd_en      (mem_rd_en),
    .mem_rd_bank    (mem_rd_bank),
    .mem_rd_addr    (mem_rd_addr),
    .mem_rdata_real (mem_rdata_real),
    .mem_rdata_imag (mem_rdata_imag),
    .to_twdl        (twdl_if),
    .busy           (busy),
    .done           (done),
    .cfg_err        (cfg_err)
`ifdef MRD_RDSEQ_PERF_EN
    ,
    .perf_cnt       (perf_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] data_re(input logic [2:0] b, input logic [AW-1:0] a);
    return DW'({b, a}) * DW'(37) + DW'(5);
  endfunction

  function automatic logic [DW-1:0] data_im(input logic [2:0] b, input logic [AW-1:0] a);
    return ~(DW'(a) * DW'(91)) ^ DW'({b, 3'b101});
  endfunction

  // Bank memory model: data appears RD_LAT cycles after the read strobe.
  logic [AW+3:0] pipe [RD_LAT];
  logic [AW+3:0] pout;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {mem_rd_en, mem_rd_bank, mem_rd_addr};
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign pout           = pipe[RD_LAT-1];
  assign mem_rdata_real = pout[AW+3] ? data_re(pout[AW+2:AW], pout[AW-1:0]) : DW'(18'h2A5A5);
  assign mem_rdata_imag = pout[AW+3] ? data_im(pout[AW+2:AW], pout[AW-1:0]) : DW'(18'h15A5A);

  // One stage run: entered and left within a cycle, after the active edge.
  task automatic run_stage(input string name, input int radix, input int ngrp,
                           input int stall_lo, input int stall_hi, input int exp_done,
                           input bit exp_err, input int restart_cyc);
    bit  accepted;
    bit  seen_done;
    int  first_valid;
    int  nvalid;
    int  cyc;
    rd_t e;
    logic [3*DW+2*BANK_W+2*AW+FSM_W+2+3-1:0] got_v, exp_v;
    accepted = (radix >= 2) && (radix <= 5) && (ngrp > 0);
    if (accepted) begin
      exp_sel  = 2'($urandom);
      exp_step = AW'($urandom);
      exp_ceil = 3'($urandom);
      for (int g = 0; g < ngrp; g++) begin
        for (int k = 0; k < radix; k++) begin
          e.bank = 3'(k);
          e.addr = AW'(g);
          rd_q.push_back(e);
          out_q.push_back(e);
        end
      end
      cfg_tw_sel   = exp_sel;
      cfg_tw_step  = exp_step;
      cfg_exp_ceil = exp_ceil;
    end
    start     = 1'b1;
    cfg_radix = 3'(radix);
    cfg_ngrp  = AW'(ngrp);
    @(posedge clk); #1;
    start       = 1'b0;
    seen_done   = 1'b0;
    first_valid = -1;
    nvalid      = 0;
    cyc         = 1;
    while (!seen_done && cyc <= 400) begin
      stall = (cyc >= stall_lo) && (cyc <= stall_hi);
      if (cyc == restart_cyc) begin
        start        = 1'b1;
        cfg_radix    = 3'd7;
        cfg_ngrp     = AW'(1);
        cfg_tw_sel   = ~exp_sel;
        cfg_tw_step  = ~exp_step;
        cfg_exp_ceil = ~exp_ceil;
      end
      #1;
      checks++;
      if (busy !== (accepted && cyc < exp_done)) begin
        failures++;
        $display("FAIL %s busy cyc=%0d got=%0b exp=%0b", name, cyc, busy, accepted && cyc < exp_done);
      end
      if (stall) begin
        checks++;
        if (mem_rd_en !== 1'b0) begin
          failures++;
          $display("FAIL %s rd_en_stall cyc=%0d got=%0b exp=0", name, cyc, mem_rd_en);
        end
      end
      if (mem_rd_en === 1'b1) begin
        checks++;
        if (rd_q.size() == 0) begin
          failures++;
          $display("FAIL %s extra_read cyc=%0d got bank=%0d addr=%0d exp none", name, cyc, mem_rd_bank, mem_rd_addr);
        end else begin
          e = rd_q.pop_front();
          if ({mem_rd_bank, mem_rd_addr} !== {e.bank, e.addr}) begin
            failures++;
            $display("FAIL %s read cyc=%0d got bank=%0d addr=%0d exp bank=%0d addr=%0d",
                     name, cyc, mem_rd_bank, mem_rd_addr, e.bank, e.addr);
          end
        end
      end
      if (twdl_if.valid === 1'b1) begin
        nvalid++;
        if (first_valid < 0) first_valid = cyc;
        checks++;
        if (out_q.size() == 0) begin
          failures++;
          $display("FAIL %s extra_valid cyc=%0d got valid=1 exp valid=0", name, cyc);
        end else begin
          e = out_q.pop_front();
          got_v = {twdl_if.d_real, twdl_if.d_imag, DW'(0), twdl_if.bank_index, twdl_if.tw_ROM_exp_time,
                   twdl_if.bank_addr, twdl_if.tw_ROM_addr_step, twdl_if.fsm, twdl_if.tw_ROM_sel,
                   twdl_if.tw_ROM_exp_ceil};
          exp_v = {data_re(e.bank, e.addr), data_im(e.bank, e.addr), DW'(0), e.bank, e.bank,
                   e.addr, exp_step, 2'd1, exp_sel, exp_ceil};
          if (got_v !== exp_v) begin
            failures++;
            $display("FAIL %s sample cyc=%0d got=%h exp=%h", name, cyc, got_v, exp_v);
          end
        end
      end
      if (cyc == 1) begin
        checks++;
        if (cfg_err !== exp_err) begin
          failures++;
          $display("FAIL %s cfg_err got=%0b exp=%0b", name, cfg_err, exp_err);
        end
`ifdef MRD_RDSEQ_PERF_EN
        if (accepted) begin
          checks++;
          if (perf_cnt !== 16'd0) begin
            failures++;
            $display("FAIL %s perf_clear got=%0d exp=0", name, perf_cnt);
          end
        end
`endif
      end
      if (done === 1'b1) begin
        seen_done = 1'b1;
        checks++;
        if (cyc != exp_done) begin
          failures++;
          $display("FAIL %s done_cycle got=%0d exp=%0d", name, cyc, exp_done);
        end
      end else begin
        @(posedge clk); #1;
        start = 1'b0;
        cyc++;
      end
    end
    stall = 1'b0;
    start = 1'b0;
    checks++;
    if (!seen_done) begin
      failures++;
      $display("FAIL %s timeout got=no_done exp=done_at_%0d", name, exp_done);
    end
    checks++;
    if (rd_q.size() != 0 || out_q.size() != 0) begin
      failures++;
      $display("FAIL %s leftover got reads=%0d samples=%0d exp=0", name, rd_q.size(), out_q.size());
    end
    rd_q.delete();
    out_q.delete();
    checks++;
    if (nvalid != (accepted ? radix * ngrp : 0)) begin
      failures++;
      $display("FAIL %s valid_count got=%0d exp=%0d", name, nvalid, accepted ? radix * ngrp : 0);
    end
    if (accepted && stall_lo != 1) begin
      checks++;
      if (first_valid != 1 + RD_LAT) begin
        failures++;
        $display("FAIL %s first_valid got=%0d exp=%0d", name, first_valid, 1 + RD_LAT);
      end
    end
`ifdef MRD_RDSEQ_PERF_EN
    if (accepted) begin
      checks++;
      if (perf_cnt !== 16'(stall_hi >= stall_lo ? stall_hi - stall_lo + 1 : 0)) begin
        failures++;
        $display("FAIL %s perf_cnt got=%0d exp=%0d", name, perf_cnt,
                 stall_hi >= stall_lo ? stall_hi - stall_lo + 1 : 0);
      end
    end
`endif
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({mem_rd_en, busy, done, cfg_err, twdl_if.valid, twdl_if.fsm, twdl_if.d_real} !== '0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=0",
               {mem_rd_en, busy, done, cfg_err, twdl_if.valid, twdl_if.fsm, twdl_if.d_real});
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_stage("r4n3", 4, 3, 0, -1, 15, 1'b0, 0);
    run_stage("r2n3", 2, 3, 0, -1, 9, 1'b0, 0);
  endtask

  task automatic test_stall();
    run_stage("r5n2_stall", 5, 2, 3, 5, 16, 1'b0, 0);
  endtask

  task automatic test_cfg_err();
    run_stage("radix6", 6, 3, 0, -1, 1, 1'b1, 0);
    run_stage("ngrp0_err_kept", 3, 0, 0, -1, 1, 1'b1, 0);
    run_stage("radix1", 1, 3, 0, -1, 1, 1'b1, 0);
    run_stage("legal_clears", 2, 1, 0, -1, 5, 1'b0, 0);
    run_stage("ngrp0", 4, 0, 0, -1, 1, 1'b0, 0);
  endtask

  task automatic test_mid_reset();
    run_stage("err_before_rst", 7, 2, 0, -1, 1, 1'b1, 0);
    start     = 1'b1;
    cfg_radix = 3'd3;
    cfg_ngrp  = AW'(8);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_rd_en, mem_rd_bank, mem_rd_addr, busy, done, cfg_err, twdl_if.valid, twdl_if.fsm,
         twdl_if.bank_index, twdl_if.bank_addr, twdl_if.d_real, twdl_if.d_imag} !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs got en=%0b busy=%0b done=%0b err=%0b valid=%0b fsm=%0d exp all 0",
               mem_rd_en, busy, done, cfg_err, twdl_if.valid, twdl_if.fsm);
    end
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if ({done, busy, twdl_if.valid} !== 3'b000) begin
        failures++;
        $display("FAIL mid_reset_hold got done=%0b busy=%0b valid=%0b exp 0", done, busy, twdl_if.valid);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    run_stage("r3n8_after_rst", 3, 8, 0, -1, 27, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    run_stage("b2b_r2n1", 2, 1, 0, -1, 5, 1'b0, 0);
    run_stage("b2b_r5n7", 5, 7, 10, 13, 42, 1'b0, 0);
    run_stage("b2b_restart_ignored", 3, 2, 0, -1, 9, 1'b0, 3);
    run_stage("b2b_drain_restart", 4, 2, 0, -1, 11, 1'b0, 9);
  endtask

  task automatic test_perf();
    run_stage("perf_r4n4", 4, 4, 5, 8, 23, 1'b0, 0);
    run_stage("perf_next", 2, 2, 0, -1, 7, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_cfg_err();
    test_mid_reset();
    test_back_to_back();
    test_perf();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mrd_rdx2345_rdseq.md
MRD_RDX2345_RDSEQ -- requirements
Module: mrd_rdx2345_rdseq

Interface
REQ-001 SHALL have parameter DW, default 18: sample real/imag width.
REQ-002 SHALL have parameter AW, default 8: bank address width.
REQ-003 SHALL have parameter RD_LAT, default 2, range 1..4: fixed bank-memory read latency in cycles.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  single-cycle request to sequence one radix stage.
REQ-007 cfg_radix  in  3  radix, legal 2..5.
REQ-008 cfg_ngrp  in  AW  number of butterfly groups.
REQ-009 cfg_tw_sel  in  2  twiddle ROM select, forwarded.
REQ-010 cfg_tw_step  in  AW  twiddle ROM address step, forwarded.
REQ-011 cfg_exp_ceil  in  3  twiddle exponent ceiling, forwarded.
REQ-012 stall  in  1  holds issue of new reads.
REQ-013 mem_rd_en  out  1  bank read strobe.
REQ-014 mem_rd_bank  out  3  bank index of read.
REQ-015 mem_rd_addr  out  AW  address within bank.
REQ-016 mem_rdata_real / mem_rdata_imag  in  DW each  read data, valid RD_LAT cycles after mem_rd_en.
REQ-017 to_twdl  out  mrd_rdx2345_if  stream to twiddle stage (fsm, valid, d_real, d_imag, bank_index, bank_addr, tw_ROM_sel, tw_ROM_addr_step, tw_ROM_exp_ceil, tw_ROM_exp_time).
REQ-018 busy  out  1  stage in progress; done  out  1  one-cycle completion pulse; cfg_err  out  1  sticky illegal-config flag.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, DRAIN; to_twdl.fsm SHALL carry the issuing state code (IDLE=0, ISSUE=1, DRAIN=2) aligned with its sample.
REQ-020 In IDLE, start with legal config (radix 2..5, ngrp>0) SHALL latch all cfg_* and enter ISSUE; start outside IDLE SHALL be ignored.
REQ-021 start with cfg_radix outside 2..5 SHALL set cfg_err, pulse done next cycle, issue no reads, remain IDLE.
REQ-022 start with cfg_ngrp=0 SHALL pulse done next cycle with no reads and no cfg_err.
REQ-023 In ISSUE with stall=0 SHALL assert mem_rd_en each cycle with mem_rd_bank=k, mem_rd_addr=g, k counting 0..radix-1 inner, g counting 0..ngrp-1 outer.
REQ-024 stall=1 SHALL deassert mem_rd_en and freeze k and g; in-flight reads SHALL still complete.
REQ-025 After read (k=radix-1, g=ngrp-1) SHALL enter DRAIN; DRAIN SHALL last RD_LAT cycles, then IDLE with done pulsed in the cycle after the last to_twdl.valid.
REQ-026 Sideband (fsm, bank_index=k, bank_addr=g, tw_exp_time=k, latched tw fields) SHALL be delayed exactly RD_LAT cycles so to_twdl.valid coincides with returned read data.
REQ-027 to_twdl.valid SHALL equal mem_rd_en delayed RD_LAT cycles; d_real/d_imag SHALL be mem_rdata registered-through with no extra latency beyond that alignment.
REQ-028 busy SHALL be 1 in ISSUE and DRAIN, 0 in IDLE.
REQ-029 Total cycles start->done for unstalled run SHALL be radix*ngrp + RD_LAT + 1.

Reset
REQ-030 rst SHALL immediately force IDLE, counters 0, delay line cleared, all outputs 0 (incl. cfg_err), regardless of operation in progress; no done pulse results.
REQ-031 cfg_err SHALL clear only on rst or on a subsequent legal start.

Configuration
REQ-032 Macro MRD_RDSEQ_PERF_EN, when defined, SHALL add output perf_cnt (16 bits) counting stall cycles within ISSUE, cleared at each accepted start, saturating at 0xFFFF; when undefined the port and counter SHALL not exist and all other behaviour SHALL be identical.

Structure
REQ-033 FSM state enum, radix limits (2, 5) and bank-index width SHALL live in shared package mrd_rdx2345_pkg.
REQ-034 Sideband alignment SHALL use one sub-module mrd_dly_line (parameterised width and depth, async active-high reset).

Verification
REQ-035 radix=4, ngrp=3, no stall -> 12 reads banks 0,1,2,3 per addr 0..2; 12 valids starting cycle 1+RD_LAT; done at cycle 15 (RD_LAT=2).
REQ-036 radix=5, ngrp=2, stall high cycles 3-5 -> mem_rd_en low 3 cycles, sequence resumes unbroken, 10 valids, done 3 cycles later than unstalled.
REQ-037 cfg_radix=6 -> cfg_err=1, done next cycle, zero reads; following legal start clears cfg_err.
REQ-038 ngrp=0 -> done next cycle, no valid, busy never high.
REQ-039 rst asserted mid-ISSUE (radix=3, ngrp=8) -> all outputs 0 same cycle, no done; new start after release runs full 24 samples.
REQ-040 With MRD_RDSEQ_PERF_EN, 4 stall cycles in ISSUE -> perf_cnt=4; next start resets it to 0.
